// File: rtl/kernel_cra_pkg.sv
// Shared register map, CTRL bit positions and FSM encoding for the kernel CRA responder.
// Pure declarations; no timing or flow-control behaviour lives here.
package kernel_cra_pkg;

  localparam int CRA_DATA_W = 64;
  localparam int CRA_BE_W   = CRA_DATA_W / 8;
  localparam int WORD_IDX_W = 5;

  localparam int REG_CTRL   = 0;
  localparam int REG_CYCLES = 1;
  localparam int REG_ARG0   = 2;

  localparam int CTRL_START   = 0;
  localparam int CTRL_BUSY    = 1;
  localparam int CTRL_DONE    = 2;
  localparam int CTRL_IRQ_EN  = 3;
  localparam int CTRL_OVERRUN = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE_ST = 2'd2
  } cra_state_e;

  // START is a write-only pulse, so it always reads back as 0.
  function automatic logic [CRA_DATA_W-1:0] pack_ctrl(
    input logic busy,
    input logic done,
    input logic irq_en,
    input logic overrun
  );
    logic [CRA_DATA_W-1:0] w;
    w               = '0;
    w[CTRL_BUSY]    = busy;
    w[CTRL_DONE]    = done;
    w[CTRL_IRQ_EN]  = irq_en;
    w[CTRL_OVERRUN] = overrun;
    return w;
  endfunction

endpackage

// File: rtl/cra_byte_reg.sv
// 64-bit read/write register with per-byte write enables.
// Write takes effect on the clock edge it is presented; no backpressure.
module cra_byte_reg
  import kernel_cra_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [CRA_BE_W-1:0]   be,
  input  logic [CRA_DATA_W-1:0] wdata,
  output logic [CRA_DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (we) begin
      for (int b = 0; b < CRA_BE_W; b++) begin
        if (be[b]) q[b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/kernel_cra_responder.sv
// Avalon-MM slave for kernel control: args, start/done/busy, run-cycle counter, completion irq.
// Reads return data 1 cycle after acceptance at 1/cycle; waitrequest only stalls the first cycle out of reset.
module kernel_cra_responder
  import kernel_cra_pkg::*;
#(
  parameter int NUM_ARGS = 4,
  parameter int ADDR_W   = 30,
  parameter int DATA_W   = 64
) (
  input  logic                       kernel_clk_clk,
  input  logic                       kernel_reset_reset_n,
  input  logic [ADDR_W-1:0]          kernel_cra_address,
  input  logic                       kernel_cra_read,
  input  logic                       kernel_cra_write,
  input  logic [DATA_W-1:0]          kernel_cra_writedata,
  input  logic [DATA_W/8-1:0]        kernel_cra_byteenable,
  input  logic                       kernel_cra_burstcount,
  input  logic                       kernel_cra_debugaccess,
  output logic                       kernel_cra_waitrequest,
  output logic [DATA_W-1:0]          kernel_cra_readdata,
  output logic                       kernel_cra_readdatavalid,
  output logic                       kernel_irq_irq,
  output logic                       kernel_start,
  output logic [DATA_W*NUM_ARGS-1:0] kernel_args,
  input  logic                       kernel_finish
);

  logic                  wait_q;
  cra_state_e            state_q;
  cra_state_e            state_d;
  logic                  launch;
  logic                  start_q;
  logic                  irq_en_q;
  logic                  overrun_q;
  logic                  irq_q;
  logic                  rdv_q;
  logic [DATA_W-1:0]     rdata_q;
  logic [DATA_W-1:0]     cycles_q;
  logic [DATA_W-1:0]     rd_mux;
  logic [DATA_W-1:0]     arg_q [NUM_ARGS];
  logic [WORD_IDX_W-1:0] word_idx;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ctrl_wr;
  logic                  start_req;
  logic                  done_clr;
  logic                  busy;
  logic                  done;
  logic                  unused_ok;

  assign word_idx = kernel_cra_address[7:3];

  // A write wins over a simultaneous read; the read is silently dropped.
  assign wr_acc = kernel_cra_write & ~wait_q;
  assign rd_acc = kernel_cra_read & ~kernel_cra_write & ~wait_q;

  assign ctrl_wr   = wr_acc && (word_idx == WORD_IDX_W'(REG_CTRL)) && kernel_cra_byteenable[0];
  assign start_req = ctrl_wr & kernel_cra_writedata[CTRL_START];
  assign done_clr  = ctrl_wr & kernel_cra_writedata[CTRL_DONE];

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE_ST);

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d = RUN;
          launch  = 1'b1;
        end
      end
      RUN: begin
        if (kernel_finish) state_d = DONE_ST;
      end
      DONE_ST: begin
        // A fresh START takes priority over clearing DONE.
        if (start_req) begin
          state_d = RUN;
          launch  = 1'b1;
        end else if (done_clr) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge kernel_clk_clk) begin
    if (!kernel_reset_reset_n) begin
      wait_q    <= 1'b1;
      state_q   <= IDLE;
      start_q   <= 1'b0;
      irq_en_q  <= 1'b0;
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
      rdv_q     <= 1'b0;
      rdata_q   <= '0;
      cycles_q  <= '0;
    end else begin
      wait_q  <= 1'b0;
      state_q <= state_d;
      start_q <= launch;

      // The finishing cycle itself is not counted as a run cycle.
      if (launch) begin
        cycles_q <= '0;
      end else if (busy && !kernel_finish && (cycles_q != '1)) begin
        cycles_q <= cycles_q + 1'b1;
      end

      if (ctrl_wr) irq_en_q <= kernel_cra_writedata[CTRL_IRQ_EN];

      if (start_req && busy) begin
        overrun_q <= 1'b1;
      end else if (ctrl_wr && kernel_cra_writedata[CTRL_OVERRUN]) begin
        overrun_q <= 1'b0;
      end

      irq_q <= done & irq_en_q;
      rdv_q <= rd_acc;
      if (rd_acc) rdata_q <= rd_mux;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (word_idx == WORD_IDX_W'(REG_CTRL)) begin
      rd_mux = pack_ctrl(busy, done, irq_en_q, overrun_q);
    end else if (word_idx == WORD_IDX_W'(REG_CYCLES)) begin
      rd_mux = cycles_q;
    end else begin
      for (int i = 0; i < NUM_ARGS; i++) begin
        if (word_idx == WORD_IDX_W'(REG_ARG0 + i)) rd_mux = arg_q[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_ARGS; g++) begin : g_arg
    logic arg_we;
    assign arg_we = wr_acc && (word_idx == WORD_IDX_W'(REG_ARG0 + g));

    cra_byte_reg u_arg (
      .clk   (kernel_clk_clk),
      .rst_n (kernel_reset_reset_n),
      .we    (arg_we),
      .be    (kernel_cra_byteenable),
      .wdata (kernel_cra_writedata),
      .q     (arg_q[g])
    );

    assign kernel_args[g*DATA_W +: DATA_W] = arg_q[g];
  end

  assign kernel_cra_waitrequest   = wait_q;
  assign kernel_cra_readdata      = rdata_q;
  assign kernel_cra_readdatavalid = rdv_q;
  assign kernel_irq_irq           = irq_q;
  assign kernel_start             = start_q;

  // Bursts are not supported: every access is a single word regardless of burstcount.
  assign unused_ok = ^{kernel_cra_address[ADDR_W-1:8], kernel_cra_address[2:0],
                       kernel_cra_burstcount, kernel_cra_debugaccess};

  a_start_in_run : assert property (@(posedge kernel_clk_clk) disable iff (!kernel_reset_reset_n)
                                    start_q |-> (state_q == RUN));

endmodule
